datadistribute_32_bit: RTL and testbench

//  Inverse of the 2:1 data selector: one source word is steered to one of two

---
 rtl/datadistribute_32_bit_pkg.sv | 16 +
 rtl/datadistribute_32_bit_slot.sv | 57 +++++
 rtl/datadistribute_32_bit.sv | 63 ++++++
 tb/tb_datadistribute_32_bit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/datadistribute_32_bit_pkg.sv
// Shared encodings for the 1:2 data distributor: destination select and slot state.
package datadistribute_32_bit_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 8;

  // Same select encoding as the 2:1 data selector
  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/datadistribute_32_bit_slot.sv
// One destination slot: output register, EMPTY/FULL valid FSM and saturating word counter.
module dist_slot
  import datadistribute_32_bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready_dn,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] cnt,
  output logic             can_load
);

  slot_state_e state_q, state_d;
  logic        drain;

  assign drain = (state_q == FULL) && ready_dn;
  assign valid = (state_q == FULL);
  // A slot can take a word when empty or emptying this cycle; never while in reset
  assign can_load = rst_n && ((state_q == EMPTY) || ready_dn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (drain && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Data holds its last value after draining; consumers qualify with valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      cnt  <= '0;
    end else if (load) begin
      dout <= din;
      if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/datadistribute_32_bit.sv
// 1:2 data distributor: steers each accepted source word into one of two output slots.
module datadistribute_32_bit
  import datadistribute_32_bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ctrl,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] data_out1,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] data_out2,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  logic can_load1, can_load2;
  logic accept, load1, load2;

  // Back-pressure is per destination: only the selected slot gates the source
  assign in_ready = (ctrl == SEL_OUT2) ? can_load2 : can_load1;
  assign accept   = in_valid && in_ready;
  assign load1    = accept && (ctrl == SEL_OUT1);
  assign load2    = accept && (ctrl == SEL_OUT2);

  dist_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load1),
    .din      (data_in),
    .ready_dn (out1_ready),
    .valid    (out1_valid),
    .dout     (data_out1),
    .cnt      (cnt1),
    .can_load (can_load1)
  );

  dist_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load2),
    .din      (data_in),
    .ready_dn (out2_ready),
    .valid    (out2_valid),
    .dout     (data_out2),
    .cnt      (cnt2),
    .can_load (can_load2)
  );

endmodule

// File: tb/tb_datadistribute_32_bit.sv
// Self-checking bench for datadistribute_32_bit against a slot-level reference model.
module tb_datadistribute_32_bit;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             ctrl;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] data_out1;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] data_out2;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per destination, is a word waiting, last word loaded, words accepted
  bit               mdl_full [2];
  logic [WIDTH-1:0] mdl_last [2];
  int               mdl_cnt  [2];

  datadistribute_32_bit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .ctrl       (ctrl),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .data_out1  (data_out1),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .data_out2  (data_out2),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      mdl_full[n] = 1'b0;
      mdl_last[n] = '0;
      mdl_cnt[n]  = 0;
    end
  endtask

  task automatic check_outputs();
    chk("out1_valid", 32'(out1_valid), 32'(mdl_full[0]));
    chk("out2_valid", 32'(out2_valid), 32'(mdl_full[1]));
    chk("data_out1",  32'(data_out1),  32'(mdl_last[0]));
    chk("data_out2",  32'(data_out2),  32'(mdl_last[1]));
    chk("cnt1",       32'(cnt1),       32'(mdl_cnt[0]));
    chk("cnt2",       32'(cnt2),       32'(mdl_cnt[1]));
  endtask

  // One clock of stimulus; called shortly after a rising edge
  task automatic step(input logic iv, input logic c, input logic [WIDTH-1:0] d,
                      input logic r1, input logic r2);
    bit rdy [2];
    bit exp_rdy;
    bit acc;
    int sel;
    in_valid   = iv;
    ctrl       = c;
    data_in    = d;
    out1_ready = r1;
    out2_ready = r2;
    rdy[0] = r1;
    rdy[1] = r2;
    sel = c ? 1 : 0;
    #2;
    exp_rdy = !mdl_full[sel] || rdy[sel];
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (mdl_full[n] && rdy[n]) mdl_full[n] = 1'b0;
    end
    if (acc) begin
      mdl_full[sel] = 1'b1;
      mdl_last[sel] = d;
      if (mdl_cnt[sel] < CNT_MAX) mdl_cnt[sel]++;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    ctrl       = 1'b0;
    data_in    = 32'hA5A5_A5A5;
    out1_ready = 1'b1;
    out2_ready = 1'b1;

    // Reset with a word offered: nothing accepted, in_ready low
    #7;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    check_outputs();
    in_valid = 1'b0;
    #5;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic route to out1
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("basic_data_out1", 32'(data_out1), 32'hDEAD_BEEF);
    chk("basic_cnt1", 32'(cnt1), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Back-pressure on out2 only
    step(1'b1, 1'b1, 32'h11, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h22, 1'b1, 1'b0);
    chk("bp_held_0x11", 32'(data_out2), 32'h11);
    step(1'b1, 1'b0, 32'h33, 1'b1, 1'b0);
    chk("bp_out1_0x33", 32'(data_out1), 32'h33);
    step(1'b1, 1'b1, 32'h22, 1'b1, 1'b1);
    chk("bp_swap_0x22", 32'(data_out2), 32'h22);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Streaming: 16 back-to-back words to out2
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b1, 1'b1);
      chk("stream_order", 32'(data_out2), 32'h1000 + 32'(i));
    end
    chk("stream_cnt2", 32'(cnt2), 32'd18);

    // Saturation of cnt1
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
    end
    chk("sat_cnt1", 32'(cnt1), 32'(CNT_MAX));

    // Both slots full and stalled, then asynchronous reset between edges
    step(1'b1, 1'b0, 32'hAAAA_0001, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_v1", 32'(out1_valid), 32'd0);
    chk("async_rst_v2", 32'(out2_valid), 32'd0);
    chk("async_rst_cnt1", 32'(cnt1), 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom), 1'($urandom), $urandom,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
